sector_write: RTL and testbench

//  Serial-to-parallel sector writer: the write-direction counterpart of the sector read serializer.

---
 rtl/sector_write.sv | 223 ++++++++++++++++++++++
 tb/tb_sector_write.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sector_write.sv
// Serial-to-parallel sector writer: hunts for a header sync, checks the 16-bit header against the
// current head position, then deserializes DATA_BYTES bytes MSB-first into the sector buffer.
module sector_write #(
  parameter int DATA_BYTES   = 400,
  parameter int ADDR_W       = 9,
  parameter int PREAMBLE_MIN = 8,
  parameter int SYNC_TIMEOUT = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        hs,
  input  logic [8:0]        cyl,
  input  logic [4:0]        sect,
  input  logic              sector_strobe,
  input  logic              wr_gate,
  input  logic              data_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              hdr_err,
  output logic              sync_err
);

  localparam int ZW = $clog2(PREAMBLE_MIN + 1);
  localparam int TW = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [ZW-1:0]     ZMIN      = ZW'(PREAMBLE_MIN);
  localparam logic [TW-1:0]     TLAST     = TW'(SYNC_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(DATA_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HSYNC = 3'd1,
    ST_HDR   = 3'd2,
    ST_DSYNC = 3'd3,
    ST_DATA  = 3'd4,
    ST_DONE  = 3'd5,
    ST_FAIL  = 3'd6
  } state_t;

  state_t            state_r, state_s;
  logic [ZW-1:0]     zcnt_r, zcnt_s;
  logic [TW-1:0]     tcnt_r, tcnt_s;
  logic [3:0]        bit_cnt_r, bit_cnt_s;
  logic [ADDR_W-1:0] byte_cnt_r, byte_cnt_s;
  logic [15:0]       hdr_r, hdr_s;
  logic [7:0]        byte_r, byte_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic [7:0]        mem_wdata_r, mem_wdata_s;
  logic              mem_we_r, mem_we_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              hdr_err_r, hdr_err_s;
  logic              sync_err_r, sync_err_s;
  logic [15:0]       hdr_shift_s;
  logic [7:0]        byte_shift_s;

  // Header field order on the wire is {hs, cyl, sect}, first-received bit in the LSB.
  function automatic logic hdr_match(input logic [15:0] h, input logic [1:0] e_hs,
                                     input logic [8:0] e_cyl, input logic [4:0] e_sect);
    return (h == {e_hs, e_cyl, e_sect});
  endfunction

  function automatic logic is_busy(input state_t s);
    return (s == ST_HSYNC) || (s == ST_HDR) || (s == ST_DSYNC) || (s == ST_DATA);
  endfunction

  assign hdr_shift_s  = {data_in, hdr_r[15:1]};
  assign byte_shift_s = {byte_r[6:0], data_in};

  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_we    = mem_we_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign hdr_err   = hdr_err_r;
  assign sync_err  = sync_err_r;

  // Next-state and next-output computation; a strobe overrides everything, including a pending write.
  always_comb begin
    state_s     = state_r;
    zcnt_s      = zcnt_r;
    tcnt_s      = tcnt_r;
    bit_cnt_s   = bit_cnt_r;
    byte_cnt_s  = byte_cnt_r;
    hdr_s       = hdr_r;
    byte_s      = byte_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    mem_we_s    = 1'b0;
    done_s      = 1'b0;
    hdr_err_s   = hdr_err_r;
    sync_err_s  = sync_err_r;
    if (sector_strobe) begin
      state_s    = ST_HSYNC;
      zcnt_s     = {ZW{1'b0}};
      tcnt_s     = {TW{1'b0}};
      bit_cnt_s  = 4'd0;
      byte_cnt_s = {ADDR_W{1'b0}};
      hdr_s      = 16'h0000;
      byte_s     = 8'h00;
      hdr_err_s  = 1'b0;
      sync_err_s = 1'b0;
    end else begin
      case (state_r)
        ST_HSYNC, ST_DSYNC: begin
          if (wr_gate && data_in && (zcnt_r >= ZMIN)) begin
            state_s   = (state_r == ST_HSYNC) ? ST_HDR : ST_DATA;
            zcnt_s    = {ZW{1'b0}};
            tcnt_s    = {TW{1'b0}};
            bit_cnt_s = 4'd0;
          end else if (tcnt_r == TLAST) begin
            state_s    = ST_FAIL;
            sync_err_s = 1'b1;
          end else begin
            // The timeout keeps running while the gate is low; only the zero count pauses.
            tcnt_s = tcnt_r + TW'(1);
            if (!wr_gate) begin
              zcnt_s = zcnt_r;
            end else if (data_in) begin
              zcnt_s = {ZW{1'b0}};
            end else if (zcnt_r < ZMIN) begin
              zcnt_s = zcnt_r + ZW'(1);
            end else begin
              zcnt_s = zcnt_r;
            end
          end
        end
        ST_HDR: begin
          if (!wr_gate) begin
            state_s    = ST_FAIL;
            sync_err_s = 1'b1;
          end else begin
            hdr_s = hdr_shift_s;
            if (bit_cnt_r == 4'd15) begin
              bit_cnt_s = 4'd0;
              if (hdr_match(hdr_shift_s, hs, cyl, sect)) begin
                state_s = ST_DSYNC;
                zcnt_s  = {ZW{1'b0}};
                tcnt_s  = {TW{1'b0}};
              end else begin
                state_s   = ST_FAIL;
                hdr_err_s = 1'b1;
              end
            end else begin
              bit_cnt_s = bit_cnt_r + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (!wr_gate) begin
            state_s    = ST_FAIL;
            sync_err_s = 1'b1;
            byte_s     = 8'h00;
            bit_cnt_s  = 4'd0;
          end else if (bit_cnt_r == 4'd7) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = byte_cnt_r;
            mem_wdata_s = byte_shift_s;
            byte_s      = 8'h00;
            bit_cnt_s   = 4'd0;
            if (byte_cnt_r == LAST_BYTE) begin
              state_s = ST_DONE;
            end else begin
              byte_cnt_s = byte_cnt_r + ADDR_W'(1);
            end
          end else begin
            byte_s    = byte_shift_s;
            bit_cnt_s = bit_cnt_r + 4'd1;
          end
        end
        ST_DONE: begin
          // mem_we is still high only on the first DONE cycle, right after the last write.
          done_s = mem_we_r;
        end
        ST_IDLE, ST_FAIL: begin
          state_s = state_r;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
    busy_s = is_busy(state_s);
  end

  // State, counters, shift registers and all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      zcnt_r      <= {ZW{1'b0}};
      tcnt_r      <= {TW{1'b0}};
      bit_cnt_r   <= 4'd0;
      byte_cnt_r  <= {ADDR_W{1'b0}};
      hdr_r       <= 16'h0000;
      byte_r      <= 8'h00;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= 8'h00;
      mem_we_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      hdr_err_r   <= 1'b0;
      sync_err_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      zcnt_r      <= zcnt_s;
      tcnt_r      <= tcnt_s;
      bit_cnt_r   <= bit_cnt_s;
      byte_cnt_r  <= byte_cnt_s;
      hdr_r       <= hdr_s;
      byte_r      <= byte_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      mem_we_r    <= mem_we_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      hdr_err_r   <= hdr_err_s;
      sync_err_r  <= sync_err_s;
    end
  end

endmodule

// File: tb/tb_sector_write.sv
// Bench for sector_write: records are composed field by field, and the expected outputs for every
// clock are derived from where each field lands in the bitstream.
module tb_sector_write;

  localparam int DB = 400;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] hs = 2'd0;
  logic [8:0] cyl = 9'd0;
  logic [4:0] sect = 5'd0;
  logic       sector_strobe = 1'b0;
  logic       wr_gate = 1'b0;
  logic       data_in = 1'b0;
  logic [8:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we, busy, done, hdr_err, sync_err;

  sector_write #(.DATA_BYTES(400), .ADDR_W(9), .PREAMBLE_MIN(8), .SYNC_TIMEOUT(512)) dut (
    .clk(clk), .rst(rst), .hs(hs), .cyl(cyl), .sect(sect),
    .sector_strobe(sector_strobe), .wr_gate(wr_gate), .data_in(data_in),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .busy(busy),
    .done(done), .hdr_err(hdr_err), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  bit         q_st[$], q_g[$], q_d[$];
  logic [1:0] q_hs[$];
  logic [8:0] q_cyl[$];
  logic [4:0] q_sect[$];
  bit         e_we[$], e_done[$], e_busy[$], e_he[$], e_se[$];
  logic [8:0] e_addr[$];
  logic [7:0] e_wd[$];
  bit         o_we[$], o_done[$], o_busy[$], o_he[$], o_se[$];

  logic [8:0] m_addr = 9'd0;
  logic [7:0] m_wdata = 8'd0;
  logic [1:0] cur_hs;
  logic [8:0] cur_cyl;
  logic [4:0] cur_sect;
  int rec_cnt = 0;
  int rec_limit = -1;
  int n_checks = 0;
  int n_err = 0;
  int cmp_idx = 0;
  bit cmp_valid = 1'b0;

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int pick_fz();
    int f;
    f = $urandom_range(0, 8);
    return (f == 8) ? -1 : f;
  endfunction

  // One clock of stimulus with the outputs that clock must produce.
  task automatic push(input bit st, input bit g, input bit d, input bit we, input logic [8:0] a,
                      input logic [7:0] wd, input bit dn, input bit bz, input bit he, input bit se);
    if (rec_limit >= 0 && rec_cnt >= rec_limit) return;
    rec_cnt++;
    if (we) begin
      m_addr = a;
      m_wdata = wd;
    end
    q_st.push_back(st); q_g.push_back(g); q_d.push_back(d);
    q_hs.push_back(cur_hs); q_cyl.push_back(cur_cyl); q_sect.push_back(cur_sect);
    e_we.push_back(we); e_addr.push_back(m_addr); e_wd.push_back(m_wdata);
    e_done.push_back(dn); e_busy.push_back(bz); e_he.push_back(he); e_se.push_back(se);
  endtask

  task automatic push_busy(input bit g, input bit d);
    push(1'b0, g, d, 1'b0, 9'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic gen_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, rb(), rb(), 1'b0, 9'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic gen_tail(input int n, input bit he, input bit se, input bit rnd);
    for (int i = 0; i < n; i++)
      push(1'b0, rnd ? rb() : 1'b1, rnd ? rb() : 1'b0, 1'b0, 9'd0, 8'd0, 1'b0, 1'b0, he, se);
  endtask

  // Preamble: optional short run ending in an ignored '1', then 8 counted zeros (gate-low pauses
  // do not count), optional extra zeros, then the sync '1'.
  task automatic gen_pre(input int fz, input bit rnd);
    int cnt = 0;
    if (fz >= 0) begin
      for (int i = 0; i < fz; i++) push_busy(1'b1, 1'b0);
      push_busy(1'b1, 1'b1);
    end
    while (cnt < 8) begin
      if (rnd && $urandom_range(0, 3) == 0) push_busy(1'b0, rb());
      else begin
        push_busy(1'b1, 1'b0);
        cnt++;
      end
    end
    if (rnd) begin
      int ex = $urandom_range(0, 3);
      for (int i = 0; i < ex; i++) push_busy(1'b1, 1'b0);
    end
    push_busy(1'b1, 1'b1);
  endtask

  // 512 clocks without a valid sync; the 512th ends the search with sync_err.
  task automatic gen_tout(input bit rnd);
    bit g, d;
    for (int k = 1; k <= 512; k++) begin
      g = rnd ? rb() : 1'b1;
      d = g ? 1'b0 : rb();
      push(1'b0, g, d, 1'b0, 9'd0, 8'd0, 1'b0, k < 512, 1'b0, k == 512);
    end
  endtask

  task automatic gen_timeout_rec(input bit rnd, input int tail);
    rec_cnt = 0;
    rec_limit = -1;
    push(1'b1, rb(), rb(), 1'b0, 9'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    gen_tout(rnd);
    gen_tail(tail, 1'b0, 1'b1, rnd);
  endtask

  // drop: index over header+data bits where the gate falls (-1 none); abort: clocks kept
  // before the next strobe cuts the record (-1 none); dto: data sync never arrives.
  task automatic gen_record(input logic [1:0] h, input logic [8:0] c, input logic [4:0] s,
                            input logic [15:0] hv, input int fz, input bit rnd, input int drop,
                            input int abort, input bit dto, input bit pat, input int tail);
    bit ended = 1'b0;
    bit he = 1'b0;
    bit se = 1'b0;
    bit match;
    int bi = 0;
    logic [7:0] val;
    rec_cnt = 0;
    rec_limit = abort;
    cur_hs = h; cur_cyl = c; cur_sect = s;
    push(1'b1, rb(), rb(), 1'b0, 9'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    gen_pre(fz, rnd);
    for (int i = 0; i < 16 && !ended; i++) begin
      if (bi == drop) begin
        push(1'b0, 1'b0, rb(), 1'b0, 9'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        se = 1'b1; ended = 1'b1;
      end else if (i == 15) begin
        match = (hv == {h, c, s});
        push(1'b0, 1'b1, hv[i], 1'b0, 9'd0, 8'd0, 1'b0, match, !match, 1'b0);
        if (!match) begin he = 1'b1; ended = 1'b1; end
      end else begin
        push_busy(1'b1, hv[i]);
      end
      bi++;
    end
    if (!ended && dto) begin
      gen_tout(rnd);
      se = 1'b1; ended = 1'b1;
    end
    if (!ended) begin
      gen_pre(rnd ? pick_fz() : -1, rnd);
      for (int n = 0; n < DB && !ended; n++) begin
        val = pat ? 8'(n ^ (n >> 8)) : 8'($urandom);
        for (int b = 7; b >= 0 && !ended; b--) begin
          if (bi == drop) begin
            push(1'b0, 1'b0, rb(), 1'b0, 9'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            se = 1'b1; ended = 1'b1;
          end else if (b == 0) begin
            push(1'b0, 1'b1, val[0], 1'b1, 9'(n), val, 1'b0, n != DB - 1, 1'b0, 1'b0);
          end else begin
            push_busy(1'b1, val[b]);
          end
          bi++;
        end
      end
    end
    if (!ended) push(1'b0, rb(), rb(), 1'b0, 9'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    gen_tail(tail, he, se, rnd);
    rec_limit = -1;
  endtask

  task automatic play(input int from);
    for (int i = from; i < q_st.size(); i++) begin
      @(negedge clk);
      sector_strobe = q_st[i]; wr_gate = q_g[i]; data_in = q_d[i];
      hs = q_hs[i]; cyl = q_cyl[i]; sect = q_sect[i];
      cmp_idx = i;
      cmp_valid = 1'b1;
    end
    @(posedge clk);
    #2;
    cmp_valid = 1'b0;
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int first_one(input bit q[$], input int lo, input int hi);
    for (int i = lo; i < hi && i < q.size(); i++) if (q[i]) return i;
    return -1;
  endfunction

  function automatic int count_ones(input bit q[$], input int lo, input int hi);
    int c = 0;
    for (int i = lo; i < hi && i < q.size(); i++) if (q[i]) c++;
    return c;
  endfunction

  // Per-clock comparison of every output against the composed expectation.
  always @(posedge clk) begin
    #1;
    if (cmp_valid) begin
      o_we.push_back(mem_we); o_done.push_back(done); o_busy.push_back(busy);
      o_he.push_back(hdr_err); o_se.push_back(sync_err);
      n_checks++;
      if ({mem_we, mem_addr, mem_wdata, done, busy, hdr_err, sync_err} !==
          {e_we[cmp_idx], e_addr[cmp_idx], e_wd[cmp_idx], e_done[cmp_idx], e_busy[cmp_idx],
           e_he[cmp_idx], e_se[cmp_idx]}) begin
        n_err++;
        $display("FAIL cycle %0d: got we=%0b addr=%0d wdata=%02h done=%0b busy=%0b hdr_err=%0b sync_err=%0b, expected we=%0b addr=%0d wdata=%02h done=%0b busy=%0b hdr_err=%0b sync_err=%0b",
                 cmp_idx, mem_we, mem_addr, mem_wdata, done, busy, hdr_err, sync_err,
                 e_we[cmp_idx], e_addr[cmp_idx], e_wd[cmp_idx], e_done[cmp_idx],
                 e_busy[cmp_idx], e_he[cmp_idx], e_se[cmp_idx]);
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check_int({tag, "_mem_addr"}, int'(mem_addr), 0);
    check_int({tag, "_mem_wdata"}, int'(mem_wdata), 0);
    check_int({tag, "_mem_we"}, int'(mem_we), 0);
    check_int({tag, "_busy"}, int'(busy), 0);
    check_int({tag, "_done"}, int'(done), 0);
    check_int({tag, "_hdr_err"}, int'(hdr_err), 0);
    check_int({tag, "_sync_err"}, int'(sync_err), 0);
  endtask

  initial begin
    int t1, t2, t3, t4, t5, t6, t6n, t6b, tend, seg_b;
    cur_hs = 2'd0; cur_cyl = 9'd0; cur_sect = 5'd0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    gen_idle(3);
    t1 = q_st.size();
    gen_record(2'd3, 9'h0D4, 5'd6, 16'hDA86, -1, 1'b0, -1, -1, 1'b0, 1'b1, 3);
    t2 = q_st.size();
    gen_record(2'd3, 9'h0D4, 5'd7, 16'hDA86, -1, 1'b0, -1, -1, 1'b0, 1'b1, 20);
    t3 = q_st.size();
    gen_record(2'd3, 9'h0D4, 5'd6, 16'hDA86, 3, 1'b0, -1, -1, 1'b0, 1'b1, 3);
    t4 = q_st.size();
    gen_record(2'd3, 9'h0D4, 5'd6, 16'hDA86, -1, 1'b0, 16 + 8 * 10 + 3, -1, 1'b0, 1'b1, 10);
    t5 = q_st.size();
    gen_timeout_rec(1'b0, 88);
    t6 = q_st.size();
    gen_record(2'd1, 9'h155, 5'd17, {2'd1, 9'h155, 5'd17}, -1, 1'b0, -1, 1642, 1'b0, 1'b1, 0);
    t6n = q_st.size();
    gen_record(2'd1, 9'h155, 5'd17, {2'd1, 9'h155, 5'd17}, -1, 1'b0, -1, -1, 1'b0, 1'b1, 2);
    t6b = q_st.size();
    gen_record(2'd2, 9'h0AA, 5'd9, {2'd2, 9'h0AA, 5'd9}, -1, 1'b1, -1, 1000, 1'b0, 1'b0, 0);
    tend = q_st.size();
    play(0);

    check_int("nominal_we_count", count_ones(o_we, t1, t2), 400);
    check_int("nominal_first_we", first_one(o_we, t1, t2) - t1, 42);
    check_int("nominal_done_latency", first_one(o_done, t1, t2) - t1, 3235);
    check_int("nominal_done_count", count_ones(o_done, t1, t2), 1);
    check_int("mismatch_hdr_err_cycle", first_one(o_he, t2, t3) - t2, 25);
    check_int("mismatch_we_count", count_ones(o_we, t2, t3), 0);
    check_int("short_pre_done_latency", first_one(o_done, t3, t4) - t3, 3239);
    check_int("gate_drop_we_count", count_ones(o_we, t4, t5), 10);
    check_int("gate_drop_sync_err_cycle", first_one(o_se, t4, t5) - t4, 118);
    check_int("gate_drop_done_count", count_ones(o_done, t4, t5), 0);
    check_int("timeout_cycle", first_one(o_se, t5, t6) - t5, 512);
    check_int("timeout_busy_after", int'(o_busy[t5 + 513]), 0);
    check_int("restart_we_count_first", count_ones(o_we, t6, t6n), 200);
    check_int("restart_done_first", count_ones(o_done, t6, t6n), 0);
    check_int("restart_we_count_second", count_ones(o_we, t6n, t6b), 400);
    check_int("restart_done_latency", first_one(o_done, t6n, t6b) - t6n, 3235);
    check_int("mid_data_busy", int'(o_busy[tend - 1]), 1);

    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs_zero("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_addr = 9'd0;
    m_wdata = 8'd0;

    seg_b = q_st.size();
    gen_idle(2);
    for (int r = 0; r < 10; r++) begin
      logic [1:0] h;
      logic [8:0] c;
      logic [4:0] s;
      int ab;
      h = 2'($urandom); c = 9'($urandom); s = 5'($urandom);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 3000)) : -1;
      case (r % 5)
        0, 1: gen_record(h, c, s, {h, c, s}, pick_fz(), 1'b1, -1, ab, 1'b0, 1'b0, $urandom_range(0, 5));
        2: gen_record(h, c, s, {h, c, s} ^ (16'h0001 << $urandom_range(0, 15)), pick_fz(), 1'b1,
                      -1, ab, 1'b0, 1'b0, $urandom_range(0, 10));
        3: gen_record(h, c, s, {h, c, s}, pick_fz(), 1'b1, $urandom_range(0, 16 + 8 * DB - 1),
                      ab, 1'b0, 1'b0, $urandom_range(0, 10));
        default: begin
          if (rb()) gen_timeout_rec(1'b1, $urandom_range(0, 10));
          else gen_record(h, c, s, {h, c, s}, pick_fz(), 1'b1, -1, -1, 1'b1, 1'b0, $urandom_range(0, 10));
        end
      endcase
    end
    play(seg_b);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
